// File: rtl/clk_step_ctrl.sv
// Clock-enable sequencer for the slow CPU: halt, free-run at a programmable rate,
// debounced single-step and N-step burst, with core-requested halt taking priority.
module clk_step_ctrl #(
  parameter int unsigned DIV_DEFAULT = 49999,
  parameter int unsigned DEB_CYCLES  = 1000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  input  logic             step_btn,
  input  logic [7:0]       burst_len,
  input  logic             halt_req,
  output logic             cpu_ce,
  output logic             running,
  output logic [1:0]       state,
  output logic [15:0]      steps_done
);

  localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StBurst = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rem_q, rem_d;
  logic             ce_q, ce_d;
  logic [15:0]      steps_q;

  logic             sync1_q, sync2_q;
  logic             deb_q;
  logic [DebW-1:0]  deb_cnt_q;
  logic             deb_done;
  logic             press;
  logic             tick;

  // Debounced level flips on the DEB_CYCLES-th consecutive cycle of disagreement.
  assign deb_done = (sync2_q != deb_q) && (deb_cnt_q == DebW'(DEB_CYCLES - 1));
  assign press    = deb_done && sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q <= step_btn;
      sync2_q <= sync1_q;
      if (sync2_q == deb_q) begin
        deb_cnt_q <= '0;
      end else if (deb_done) begin
        deb_q     <= sync2_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + DebW'(1);
      end
    end
  end

  // A reload restarts the period, so a tick landing on the load cycle is dropped.
  assign tick = (state_q != StIdle) && (cnt_q == div_q) && !div_load;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ce_d    = 1'b0;
    div_d   = div_load ? div_val : div_q;
    if (div_load || (state_q == StIdle) || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (!halt_req) begin
          if (mode == 2'b01) begin
            state_d = StRun;
          end else if (mode == 2'b10) begin
            ce_d = press;
          end else if ((mode == 2'b11) && press && (burst_len != 8'd0)) begin
            rem_d   = burst_len;
            state_d = StBurst;
          end
        end
      end
      StRun: begin
        ce_d = tick && !halt_req;
        if (halt_req || (mode != 2'b01)) begin
          state_d = StIdle;
        end
      end
      StBurst: begin
        if (halt_req || (mode == 2'b00)) begin
          state_d = StIdle;
          rem_d   = 8'd0;
        end else if (tick) begin
          ce_d  = 1'b1;
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      div_q   <= CNT_W'(DIV_DEFAULT);
      cnt_q   <= '0;
      rem_q   <= 8'd0;
      ce_q    <= 1'b0;
      steps_q <= 16'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      ce_q    <= ce_d;
      steps_q <= steps_q + {15'd0, ce_d};
    end
  end

  assign cpu_ce     = ce_q;
  assign running    = (state_q != StIdle);
  assign state      = state_q;
  assign steps_done = steps_q;

endmodule
